vend_dispense_ctrl: RTL
=======================

Name: vend_dispense_ctrl

Overview:
- Sequences the physical side of a purchase once the vending front-end FSM has accepted an item number and credit.
- Checks the request, pulses the slot motor, waits for the drop sensor with a timeout, then pays change or a refund one coin unit per pulse.
- Owns per-slot stock counters and a restock path used in maintenance mode.
- Sits between the front-end FSM (request side) and the motor, drop-sensor and coin-hopper drivers.

Parameters:
- N_ITEMS, 10, number of item slots; req_item and restock_item are 4 bits, so N_ITEMS must not exceed 16.
- STOCK_W, 4, width of each stock counter.
- STOCK_INIT, 5, stock value loaded into every slot at reset.
- CREDIT_W, 8, width of price and credit, in coin units.
- MOTOR_CYC, 8, number of cycles the motor is held on.
- DROP_TIMEOUT, 64, cycles allowed for drop_sense after the motor stops.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  purchase request from the front-end
- req_item  in  4  requested slot number
- req_price  in  CREDIT_W  price of the item
- req_credit  in  CREDIT_W  credit inserted
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready
- motor_en  out  N_ITEMS  one-hot motor drive
- drop_sense  in  1  item-dropped sensor, synchronous level
- coin_out  out  1  one-cycle pulse per coin unit paid out
- done  out  1  one-cycle pulse on a successful vend
- fail  out  1  one-cycle pulse on a rejected or failed vend
- out_of_stock  out  N_ITEMS  bit i high when stock[i]==0
- busy  out  1  high whenever the state is not IDLE
- restock  in  1  restock strobe
- restock_item  in  4  slot to restock

Behaviour:
- Reset values: state IDLE; all stock counters = STOCK_INIT; motor_en=0, coin_out=0, done=0, fail=0, busy=0; req_ready=1.
- Reset asserted mid-operation aborts immediately: motor off, no further coins; the interrupted coin payout is lost.
- States: IDLE, CHECK, MOTOR, WAIT_DROP, CHANGE, REFUND, DONE, FAIL.
- IDLE: on accept, latch item, price and credit, then go to CHECK. Inputs are not resampled afterwards.
- CHECK (1 cycle):
  - item >= N_ITEMS, or credit < price, or stock[item]==0 -> FAIL; no coins paid, the front-end keeps the credit.
  - otherwise -> MOTOR; the remaining-coin count is loaded with credit - price (unsigned, never negative here).
- MOTOR: motor_en[item]=1 for exactly MOTOR_CYC cycles, then -> WAIT_DROP.
- WAIT_DROP: timeout counter starts at 0.
  - drop_sense=1 -> decrement stock[item], then -> CHANGE.
  - counter reaches DROP_TIMEOUT-1 with no drop -> load the coin count with the full credit, then -> REFUND.
  - drop_sense high in the same cycle as the timeout is a success.
- CHANGE and REFUND payout:
  - while the count is nonzero, pulse coin_out, then hold one gap cycle; pulses are therefore every 2 cycles.
  - each pulse decrements the count.
  - count==0 on entry means no pulses.
  - CHANGE exits to DONE; REFUND exits to FAIL.
- DONE: done=1 for one cycle -> IDLE. FAIL: fail=1 for one cycle -> IDLE.
- Stock counters:
  - decrement only on a successful drop, never below 0.
  - restock=1 with busy=0 sets stock[restock_item] to all-ones (saturating full).
  - restock while busy, or with restock_item >= N_ITEMS, is ignored.
- out_of_stock is combinational from the stock counters.

Optional Feature:
- Macro VEND_AUDIT_EN.
- When defined: adds output sales_count (16 bits, reset 0). It increments on every done pulse and saturates at 0xFFFF. Also adds output refund_count (8 bits, reset 0), which increments on every timeout refund and saturates.
- When undefined: neither port exists and the counting logic is absent.

Decomposition:
- Shared package vend_pkg holds:
  - the state enum, 3-bit encoding;
  - default constants N_ITEMS_D, CREDIT_W_D, MOTOR_CYC_D, DROP_TIMEOUT_D;
  - the typedef credit_t.
- One sub-module, vend_coin_payout: loads a count, emits pulse/gap pairs, and asserts payout_done. It is shared by the CHANGE and REFUND states.

Test Plan:
- Normal vend: item 2, price 3, credit 5, drop_sense 2 cycles after the motor stops. Required: motor_en=0000000100 for 8 cycles; stock[2] goes 5->4; 2 coin_out pulses 2 cycles apart; then done; busy returns to 0.
- Rejects: item 12, or credit 2 with price 3. Required: fail pulse 2 cycles after accept; no motor; no coins; stock unchanged.
- Empty slot: vend item 0 five times, then a sixth request. Required: out_of_stock[0]=1 after the fifth vend; the sixth request fails in CHECK.
- Timeout: credit 4, drop_sense never asserted. Required: after DROP_TIMEOUT cycles, 4 refund pulses, then fail; stock unchanged.
- Async reset asserted during MOTOR and during CHANGE. Required: outputs clear immediately; stock returns to STOCK_INIT; req_ready=1.
- Restock: restock item 0 while idle sets stock[0]=15 and clears out_of_stock[0]; restock while busy is ignored. With VEND_AUDIT_EN defined, sales_count matches the number of done pulses.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and default constants for the vending dispense controller.
package vend_pkg;

  localparam int N_ITEMS_D      = 10;
  localparam int STOCK_W_D      = 4;
  localparam int STOCK_INIT_D   = 5;
  localparam int CREDIT_W_D     = 8;
  localparam int MOTOR_CYC_D    = 8;
  localparam int DROP_TIMEOUT_D = 64;

  typedef logic [CREDIT_W_D-1:0] credit_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_MOTOR     = 3'd2,
    ST_WAIT_DROP = 3'd3,
    ST_CHANGE    = 3'd4,
    ST_REFUND    = 3'd5,
    ST_DONE      = 3'd6,
    ST_FAIL      = 3'd7
  } vend_state_t;

endpackage

// File: rtl/vend_dispense_ctrl_if.sv
// Purchase request handshake between the front-end FSM (master) and the dispense controller (slave).
interface vend_dispense_ctrl_if import vend_pkg::*; #(
  parameter int CREDIT_W = CREDIT_W_D
) ();

  logic                req_valid;
  logic [3:0]          req_item;
  logic [CREDIT_W-1:0] req_price;
  logic [CREDIT_W-1:0] req_credit;
  logic                req_ready;

  modport master (
    output req_valid, req_item, req_price, req_credit,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_item, req_price, req_credit,
    output req_ready
  );

endinterface

// File: rtl/vend_coin_payout.sv
// Coin payout engine: loads a coin count and emits one coin_out pulse followed by one gap cycle per unit.
module vend_coin_payout import vend_pkg::*; #(
  parameter int W = CREDIT_W_D
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_count,
  output logic         coin_out,
  output logic         payout_done
);

  logic [W-1:0] count_r;
  logic         active_r;
  logic         gap_r;
  logic         coin_r;
  logic         done_r;

  // Pulse/gap sequencer; payout_done pulses once the count has drained
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r  <= {W{1'b0}};
      active_r <= 1'b0;
      gap_r    <= 1'b0;
      coin_r   <= 1'b0;
      done_r   <= 1'b0;
    end else if (load) begin
      count_r  <= load_count;
      active_r <= 1'b1;
      gap_r    <= 1'b0;
      coin_r   <= 1'b0;
      done_r   <= 1'b0;
    end else if (!active_r) begin
      gap_r  <= 1'b0;
      coin_r <= 1'b0;
      done_r <= 1'b0;
    end else if (gap_r) begin
      gap_r  <= 1'b0;
      coin_r <= 1'b0;
    end else if (count_r != {W{1'b0}}) begin
      coin_r  <= 1'b1;
      gap_r   <= 1'b1;
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      coin_r   <= 1'b0;
      done_r   <= 1'b1;
      active_r <= 1'b0;
    end
  end

  assign coin_out    = coin_r;
  assign payout_done = done_r;

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Vending dispense sequencer: check, motor pulse, drop wait with timeout, change/refund payout, stock.
// Optional audit counters (sales_count, refund_count) are built when VEND_AUDIT_EN is defined.
module vend_dispense_ctrl import vend_pkg::*; #(
  parameter int N_ITEMS      = N_ITEMS_D,
  parameter int STOCK_W      = STOCK_W_D,
  parameter int STOCK_INIT   = STOCK_INIT_D,
  parameter int CREDIT_W     = CREDIT_W_D,
  parameter int MOTOR_CYC    = MOTOR_CYC_D,
  parameter int DROP_TIMEOUT = DROP_TIMEOUT_D
) (
  input  logic               clk,
  input  logic               rst,
  vend_dispense_ctrl_if.slave req,
  output logic [N_ITEMS-1:0] motor_en,
  input  logic               drop_sense,
  output logic               coin_out,
  output logic               done,
  output logic               fail,
  output logic [N_ITEMS-1:0] out_of_stock,
  output logic               busy,
  input  logic               restock,
  input  logic [3:0]         restock_item
`ifdef VEND_AUDIT_EN
  ,
  output logic [15:0]        sales_count,
  output logic [7:0]         refund_count
`endif
);

  localparam int MC_W = $clog2(MOTOR_CYC + 1);
  localparam int TO_W = $clog2(DROP_TIMEOUT + 1);

  vend_state_t         state_r;
  logic [3:0]          item_r;
  logic [CREDIT_W-1:0] price_r;
  logic [CREDIT_W-1:0] credit_r;
  logic [CREDIT_W-1:0] pay_count_r;
  logic                pay_load_r;
  logic [MC_W-1:0]     motor_cnt_r;
  logic [TO_W-1:0]     wait_cnt_r;
  logic [N_ITEMS-1:0]  motor_en_r;
  logic                done_r;
  logic                fail_r;
  logic                busy_r;
  logic                req_ready_r;
  logic [STOCK_W-1:0]  stock_r [N_ITEMS];
  logic [N_ITEMS-1:0]  oos_s;
  logic                check_bad_s;
  logic                drop_s;
  logic                timeout_s;
  logic                restock_s;
  logic                coin_s;
  logic                payout_done_s;

  // Request screening and drop/timeout/restock strobes
  always_comb begin
    check_bad_s = ({1'b0, item_r} >= 5'(N_ITEMS)) || (credit_r < price_r) ||
                  (stock_r[item_r] == {STOCK_W{1'b0}});
    drop_s      = (state_r == ST_WAIT_DROP) && drop_sense;
    timeout_s   = (state_r == ST_WAIT_DROP) && !drop_sense &&
                  (wait_cnt_r == TO_W'(DROP_TIMEOUT - 1));
    restock_s   = restock && !busy_r && ({1'b0, restock_item} < 5'(N_ITEMS));
  end

  // Main sequencer with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      item_r      <= 4'd0;
      price_r     <= {CREDIT_W{1'b0}};
      credit_r    <= {CREDIT_W{1'b0}};
      pay_count_r <= {CREDIT_W{1'b0}};
      pay_load_r  <= 1'b0;
      motor_cnt_r <= {MC_W{1'b0}};
      wait_cnt_r  <= {TO_W{1'b0}};
      motor_en_r  <= {N_ITEMS{1'b0}};
      done_r      <= 1'b0;
      fail_r      <= 1'b0;
      busy_r      <= 1'b0;
      req_ready_r <= 1'b1;
    end else begin
      done_r     <= 1'b0;
      fail_r     <= 1'b0;
      pay_load_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req.req_valid && req_ready_r) begin
            item_r      <= req.req_item;
            price_r     <= req.req_price;
            credit_r    <= req.req_credit;
            state_r     <= ST_CHECK;
            busy_r      <= 1'b1;
            req_ready_r <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (check_bad_s) begin
            state_r <= ST_FAIL;
            fail_r  <= 1'b1;
          end else begin
            state_r     <= ST_MOTOR;
            motor_en_r  <= {{(N_ITEMS-1){1'b0}}, 1'b1} << item_r;
            motor_cnt_r <= {MC_W{1'b0}};
            pay_count_r <= credit_r - price_r;
          end
        end
        ST_MOTOR: begin
          if (motor_cnt_r == MC_W'(MOTOR_CYC - 1)) begin
            motor_en_r <= {N_ITEMS{1'b0}};
            wait_cnt_r <= {TO_W{1'b0}};
            state_r    <= ST_WAIT_DROP;
          end else begin
            motor_cnt_r <= motor_cnt_r + MC_W'(1);
          end
        end
        ST_WAIT_DROP: begin
          // A drop seen on the timeout cycle still counts as a vend
          if (drop_s) begin
            state_r    <= ST_CHANGE;
            pay_load_r <= 1'b1;
          end else if (timeout_s) begin
            state_r     <= ST_REFUND;
            pay_count_r <= credit_r;
            pay_load_r  <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + TO_W'(1);
          end
        end
        ST_CHANGE: begin
          if (payout_done_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end
        end
        ST_REFUND: begin
          if (payout_done_s) begin
            state_r <= ST_FAIL;
            fail_r  <= 1'b1;
          end
        end
        ST_DONE, ST_FAIL: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          req_ready_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_IDLE;
          motor_en_r  <= {N_ITEMS{1'b0}};
          busy_r      <= 1'b0;
          req_ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Per-slot stock: restock to full while idle, decrement on a sensed drop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_ITEMS; i++) stock_r[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      for (int i = 0; i < N_ITEMS; i++) begin
        if (restock_s && (restock_item == 4'(i))) begin
          stock_r[i] <= {STOCK_W{1'b1}};
        end else if (drop_s && (item_r == 4'(i)) && (stock_r[i] != {STOCK_W{1'b0}})) begin
          stock_r[i] <= stock_r[i] - {{(STOCK_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Empty-slot flags straight from the counters
  always_comb begin
    oos_s = {N_ITEMS{1'b0}};
    for (int i = 0; i < N_ITEMS; i++) oos_s[i] = (stock_r[i] == {STOCK_W{1'b0}});
  end

  vend_coin_payout #(.W(CREDIT_W)) u_payout (
    .clk         (clk),
    .rst         (rst),
    .load        (pay_load_r),
    .load_count  (pay_count_r),
    .coin_out    (coin_s),
    .payout_done (payout_done_s)
  );

`ifdef VEND_AUDIT_EN
  logic [15:0] sales_r;
  logic [7:0]  refund_r;

  // Saturating audit counters for completed vends and timeout refunds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sales_r  <= 16'd0;
      refund_r <= 8'd0;
    end else begin
      if (done_r && (sales_r != 16'hFFFF)) sales_r <= sales_r + 16'd1;
      if (timeout_s && (refund_r != 8'hFF)) refund_r <= refund_r + 8'd1;
    end
  end

  assign sales_count  = sales_r;
  assign refund_count = refund_r;
`endif

  assign req.req_ready = req_ready_r;
  assign motor_en      = motor_en_r;
  assign coin_out      = coin_s;
  assign done          = done_r;
  assign fail          = fail_r;
  assign busy          = busy_r;
  assign out_of_stock  = oos_s;

endmodule
